// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and sizing helpers for the sqrt arbiter and its result FIFO.
// The entry struct is sized by the default build widths below.
package sqrt_ctrl_pkg;

    function automatic int calc_lat(input int stages);
        return stages - 1;
    endfunction

    function automatic int calc_tagw(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

    localparam int SQRT_WIDTH = 26;
    localparam int SQRT_NREQ  = 2;
    localparam int SQRT_TAGW  = calc_tagw(SQRT_NREQ);

    typedef logic [SQRT_TAGW-1:0] sqrt_tag_t;

    typedef struct packed {
        logic [SQRT_WIDTH-1:0] data;
        logic                  sticky;
        sqrt_tag_t             tag;
    } sqrt_entry_t;

endpackage

// File: rtl/sqrt_res_fifo.sv
// In-order result FIFO with a write pointer, a read pointer and an occupancy count.
// The credit counter upstream keeps writes away from a full FIFO.
module sqrt_res_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wdata;
                wptr      <= next_ptr(wptr);
            end
            if (do_rd) rptr <= next_ptr(rptr);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (!do_wr && do_rd) count <= count - CW'(1);
        end
    end

    // Overflow would mean the credit accounting upstream is broken.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(wr && full));
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one non-stallable pipelined sqrt between requesters;
// results are credit-protected in an output FIFO so backpressure never stalls sqrt.
module sqrt_arbiter
    import sqrt_ctrl_pkg::*;
#(
    parameter int  WIDTH  = SQRT_WIDTH,
    parameter int  STAGES = 3,
    parameter int  NREQ   = SQRT_NREQ,
    parameter int  DEPTH  = 4,
    localparam int TAGW   = calc_tagw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      sq_in,
    input  logic [WIDTH-1:0]      sq_out,
    input  logic                  sq_sticky,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_sticky,
    output logic [TAGW-1:0]       res_tag,
    output logic                  busy
);
    localparam int LAT = calc_lat(STAGES);
    localparam int UW  = $clog2(DEPTH + 1);

    logic [UW-1:0]     used;
    logic [TAGW-1:0]   last;
    logic [TAGW-1:0]   win;
    logic              found;
    logic              grant_ok;
    logic              accept;
    logic              pop;
    logic [2*NREQ-1:0] rot;
    logic [WIDTH-1:0]  sel_data;
    logic              iss_v;
    logic [WIDTH-1:0]  iss_data;
    logic [TAGW-1:0]   iss_tag;
    logic              tail_v;
    logic [TAGW-1:0]   tail_tag;
    logic              fifo_full;
    logic              fifo_empty;
    sqrt_entry_t       wr_entry;
    sqrt_entry_t       head;

    assign pop      = res_valid && res_ready;
    assign grant_ok = (used < UW'(DEPTH)) || pop;
    assign accept   = found && grant_ok;

    // Rotate the request vector so the search begins just past the last winner.
    always_comb begin
        found    = 1'b0;
        win      = last;
        sel_data = '0;
        rot      = {req_valid, req_valid} >> (int'(last) + 1);
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                win   = TAGW'((int'(last) + 1 + i) % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (win == TAGW'(i));
            if (win == TAGW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used     <= '0;
            last     <= TAGW'(NREQ - 1);
            iss_v    <= 1'b0;
            iss_data <= '0;
            iss_tag  <= '0;
        end else begin
            iss_v <= accept;
            if (accept) begin
                iss_data <= sel_data;
                iss_tag  <= win;
                last     <= win;
            end
            if (accept && !pop)      used <= used + UW'(1);
            else if (!accept && pop) used <= used - UW'(1);
        end
    end

    // Tags ride alongside the sqrt pipeline; valids clear on reset so stale results drop.
    generate
        if (LAT == 0) begin : g_direct
            assign tail_v   = iss_v;
            assign tail_tag = iss_tag;
        end else begin : g_track
            logic [LAT-1:0]  trk_v;
            logic [TAGW-1:0] trk_tag [LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    trk_v <= '0;
                    for (int i = 0; i < LAT; i++) trk_tag[i] <= '0;
                end else begin
                    trk_v[0]   <= iss_v;
                    trk_tag[0] <= iss_tag;
                    for (int i = 1; i < LAT; i++) begin
                        trk_v[i]   <= trk_v[i-1];
                        trk_tag[i] <= trk_tag[i-1];
                    end
                end
            end
            assign tail_v   = trk_v[LAT-1];
            assign tail_tag = trk_tag[LAT-1];
        end
    endgenerate

    assign wr_entry = '{data: sq_out, sticky: sq_sticky, tag: tail_tag};

    sqrt_res_fifo #(
        .W     ($bits(sqrt_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tail_v),
        .wdata (wr_entry),
        .rd    (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sq_in      = iss_data;
    assign res_valid  = !fifo_empty;
    assign res_data   = head.data;
    assign res_sticky = head.sticky;
    assign res_tag    = head.tag;
    assign busy       = (used != '0);

endmodule
